// File: rtl/status_blink_encoder.sv
// Status LED driver: mirrors the 1 Hz heartbeat when healthy, or blinks a nonzero fault code
// as N pulses followed by a dark gap. Define STATUS_BLINK_SYNC_EN to synchronize heartbeat_in.
module status_blink_encoder #(
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic              input_clock,
  input  logic              reset_n,
  input  logic              heartbeat_in,
  input  logic [CODE_W-1:0] fault_code,
  output logic              led_out,
  output logic              seq_busy,
  output logic [CODE_W-1:0] code_shown,
  output logic              seq_done
);

  localparam int unsigned GcntW = $clog2(GAP_TICKS + 1);
  localparam logic [GcntW-1:0] GapLoad = GcntW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  logic              hb_s;
  logic              hb_d;
  logic              tick;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] cnt_q, cnt_d;
  logic [GcntW-1:0]  gcnt_q, gcnt_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              done_q, done_d;

`ifdef STATUS_BLINK_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], heartbeat_in};
    end
  end

  assign hb_s = sync_q[1];
`else
  assign hb_s = heartbeat_in;
`endif

  // Every heartbeat edge, rising or falling, is one half-second tick.
  assign tick = hb_s ^ hb_d;

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) begin
      hb_d    <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      hb_d    <= hb_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    led_d   = led_q;
    busy_d  = busy_q;
    code_d  = code_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        led_d = (fault_code == '0) ? hb_s : 1'b0;
        if (tick && (fault_code != '0)) begin
          code_d  = fault_code;
          cnt_d   = fault_code - CODE_W'(1);
          led_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = StOn;
        end
      end
      StOn: begin
        if (tick) begin
          led_d   = 1'b0;
          state_d = StOff;
        end
      end
      StOff: begin
        if (tick) begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CODE_W'(1);
            led_d   = 1'b1;
            state_d = StOn;
          end else begin
            gcnt_d  = GapLoad;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        led_d = 1'b0;
        if (tick) begin
          if (gcnt_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            code_d  = '0;
            done_d  = 1'b1;
          end else begin
            gcnt_d = gcnt_q - GcntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign led_out    = led_q;
  assign seq_busy   = busy_q;
  assign code_shown = code_q;
  assign seq_done   = done_q;

endmodule

// File: tb/tb_status_blink_encoder.sv
// Scoreboard bench for status_blink_encoder: two instances (gap 4 and gap 1) share the stimulus;
// each heartbeat edge pushes the expected per-tick outputs, which are popped when the DUT responds.
module tb_status_blink_encoder;

`ifdef STATUS_BLINK_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif
  localparam int HalfCycles = 10;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [3:0] code;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hb;
  logic [3:0] fault;
  logic       led_a, busy_a, done_a;
  logic       led_b, busy_b, done_b;
  logic [3:0] code_a, code_b;

  exp_t        pend_a[$];
  exp_t        pend_b[$];
  bit [1:0]    last_led;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  status_blink_encoder #(.CODE_W(4), .GAP_TICKS(4)) dut_a (
    .input_clock (clk),
    .reset_n     (rst_n),
    .heartbeat_in(hb),
    .fault_code  (fault),
    .led_out     (led_a),
    .seq_busy    (busy_a),
    .code_shown  (code_a),
    .seq_done    (done_a)
  );

  status_blink_encoder #(.CODE_W(4), .GAP_TICKS(1)) dut_b (
    .input_clock (clk),
    .reset_n     (rst_n),
    .heartbeat_in(hb),
    .fault_code  (fault),
    .led_out     (led_b),
    .seq_busy    (busy_b),
    .code_shown  (code_b),
    .seq_done    (done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // On a tick seen in idle, queue either one mirror entry or a whole blink sequence.
  task automatic model_tick(input int idx, input int unsigned g);
    exp_t        e;
    int unsigned n;
    int          sz;
    n  = 32'(fault);
    sz = (idx == 0) ? pend_a.size() : pend_b.size();
    if (sz != 0) return;
    if (n == 0) begin
      e = '{led: hb, busy: 1'b0, code: 4'd0, done: 1'b0};
      if (idx == 0) pend_a.push_back(e); else pend_b.push_back(e);
      return;
    end
    for (int unsigned k = 1; k <= 2 * n + g + 1; k++) begin
      if (k <= 2 * n) begin
        e = '{led: k[0], busy: 1'b1, code: n[3:0], done: 1'b0};
      end else if (k <= 2 * n + g) begin
        e = '{led: 1'b0, busy: 1'b1, code: n[3:0], done: 1'b0};
      end else begin
        e = '{led: 1'b0, busy: 1'b0, code: 4'd0, done: 1'b1};
      end
      if (idx == 0) pend_a.push_back(e); else pend_b.push_back(e);
    end
  endtask

  task automatic compare_outs(input int idx);
    exp_t e;
    if (idx == 0) begin
      e = pend_a.pop_front();
      check_val("led_a", 32'(led_a), 32'(e.led));
      check_val("busy_a", 32'(busy_a), 32'(e.busy));
      check_val("code_a", 32'(code_a), 32'(e.code));
      check_val("done_a", 32'(done_a), 32'(e.done));
    end else begin
      e = pend_b.pop_front();
      check_val("led_b", 32'(led_b), 32'(e.led));
      check_val("busy_b", 32'(busy_b), 32'(e.busy));
      check_val("code_b", 32'(code_b), 32'(e.code));
      check_val("done_b", 32'(done_b), 32'(e.done));
    end
    last_led[idx] = e.led;
  endtask

  // One heartbeat edge: outputs must hold until exactly Lat cycles after the edge.
  task automatic hb_step();
    logic [1:0] prev;
    prev[0] = (pend_a.size() == 0) ? ((fault == 4'd0) ? hb : 1'b0) : last_led[0];
    prev[1] = (pend_b.size() == 0) ? ((fault == 4'd0) ? hb : 1'b0) : last_led[1];
    cyc();
    hb = ~hb;
    model_tick(0, 4);
    model_tick(1, 1);
    for (int i = 0; i < Lat - 1; i++) cyc();
    check_val("led_a_hold", 32'(led_a), 32'(prev[0]));
    check_val("led_b_hold", 32'(led_b), 32'(prev[1]));
    cyc();
    compare_outs(0);
    compare_outs(1);
    cyc();
    check_val("done_a_width", 32'(done_a), 0);
    check_val("done_b_width", 32'(done_b), 0);
    for (int i = 0; i < HalfCycles - Lat - 2; i++) cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (pend_a.size() != 0 || pend_b.size() != 0); i++) hb_step();
  endtask

  task automatic check_reset();
    check_val("rst_led_a", 32'(led_a), 0);
    check_val("rst_busy_a", 32'(busy_a), 0);
    check_val("rst_code_a", 32'(code_a), 0);
    check_val("rst_done_a", 32'(done_a), 0);
    check_val("rst_led_b", 32'(led_b), 0);
    check_val("rst_busy_b", 32'(busy_b), 0);
    check_val("rst_code_b", 32'(code_b), 0);
    check_val("rst_done_b", 32'(done_b), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    hb    = 1'b0;
    fault = 4'd0;
    last_led = '0;
    repeat (3) cyc();
    check_reset();
    rst_n = 1'b1;
    cyc();
    cyc();

    // healthy: LED mirrors the heartbeat
    repeat (6) hb_step();

    // code 3, left asserted long enough to restart
    fault = 4'd3;
    repeat (12) hb_step();
    fault = 4'd0;
    drain();

    // code change during the first ON is ignored until the next start
    fault = 4'd2;
    hb_step();
    fault = 4'd5;
    repeat (23) hb_step();
    fault = 4'd0;
    drain();

    // maximum code, cleared during blink 4: sequence still completes
    fault = 4'd15;
    repeat (7) hb_step();
    fault = 4'd0;
    drain();
    repeat (3) hb_step();

    // minimum code with back-to-back restarts
    fault = 4'd1;
    repeat (12) hb_step();
    fault = 4'd0;
    drain();

    // asynchronous reset while in ON
    fault = 4'd3;
    hb_step();
    rst_n = 1'b0;
    #1;
    check_reset();
    pend_a.delete();
    pend_b.delete();
    hb    = 1'b0;
    fault = 4'd0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    repeat (4) hb_step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
